vga_controller: RTL and testbench

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_controller_if.sv | 20 ++
 rtl/vga_controller.sv | 70 +++++++
 tb/tb_vga_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_controller_if.sv
// vga_controller_if: raster position, sync and colour signals between the VGA timing core and its pixel sources
interface vga_if;
  logic [2:0] rgb_in;
  logic [9:0] row;
  logic [9:0] col;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb_out;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_start;
  modport master (
    input  rgb_in,
    output row, col, hsync, vsync, rgb_out, video_on, pixel_tick, frame_start
  );
  modport slave (
    output rgb_in,
    input  row, col, hsync, vsync, rgb_out, video_on, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_controller.sv
// vga_controller: pixel-clock divider, raster counters and registered sync/colour outputs
module vga_controller #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input logic   clk,
  input logic   reset,
  vga_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] r_div;
  logic [9:0]    r_col;
  logic [9:0]    r_row;
  logic [2:0]    r_rgb;
  logic          r_hsync;
  logic          r_vsync;
  logic          w_tick;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_video_on;
  logic          w_hsync_raw;
  logic          w_vsync_raw;
  assign w_tick      = r_div == DW'(CLK_DIV - 1);
  assign w_col_last  = r_col == 10'(H_TOTAL - 1);
  assign w_row_last  = r_row == 10'(V_TOTAL - 1);
  assign w_video_on  = (r_col < 10'(H_VISIBLE)) && (r_row < 10'(V_VISIBLE));
  assign w_hsync_raw = !((r_col >= 10'(H_VISIBLE + H_FRONT)) && (r_col < 10'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign w_vsync_raw = !((r_row >= 10'(V_VISIBLE + V_FRONT)) && (r_row < 10'(V_VISIBLE + V_FRONT + V_SYNC)));
  // divider wraps after CLK_DIV-1 so one tick fires every CLK_DIV clocks
  always_ff @(posedge clk or posedge reset)
    if (reset) r_div <= '0;
    else       r_div <= w_tick ? '0 : r_div + 1'b1;
  // col advances every tick; row advances only on the tick where col wraps
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_tick) begin
      r_col <= w_col_last ? '0 : r_col + 10'd1;
      if (w_col_last) r_row <= w_row_last ? '0 : r_row + 10'd1;
    end
  // colour and syncs are captured together on the tick so they stay pixel-aligned
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rgb   <= 3'b000;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_rgb   <= w_video_on ? bus.rgb_in : 3'b000;
      r_hsync <= w_hsync_raw;
      r_vsync <= w_vsync_raw;
    end
  assign bus.row         = r_row;
  assign bus.col         = r_col;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.rgb_out     = r_rgb;
  assign bus.video_on    = w_video_on;
  assign bus.pixel_tick  = w_tick;
  assign bus.frame_start = w_tick && w_col_last && w_row_last;
endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: directed checks on default, fast-small and divide-by-4 controller instances
module tb_vga_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  vga_if bus_def ();
  vga_if bus_sm ();
  vga_if bus_d4 ();
  vga_controller u_def (.clk(clk), .reset(reset), .bus(bus_def));
  vga_controller #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_sm (.clk(clk), .reset(reset), .bus(bus_sm));
  vga_controller #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_d4 (.clk(clk), .reset(reset), .bus(bus_d4));
  always #5 clk = ~clk;
  logic [9:0] dcol [0:1700];
  logic [9:0] drow [0:1700];
  logic       dhs  [0:1700];
  logic [2:0] drgb [0:1700];
  logic       dtk  [0:1700];
  logic [9:0] scol [0:98];
  logic [9:0] srow [0:98];
  logic       shs  [0:98];
  logic       svs  [0:98];
  logic       sfs  [0:98];
  logic [2:0] srgb [0:98];
  logic       svid [0:98];
  logic [2:0] qrgb [0:20];
  logic       qtk  [0:20];
  int hs_lo_def, hs_lo_sm, vs_lo_sm, fs_sm, tk_sm;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  initial begin
    bus_def.rgb_in = 3'b101;
    bus_sm.rgb_in  = 3'b101;
    bus_d4.rgb_in  = 3'b111;
    repeat (2) @(negedge clk);
    chk("rst_col", bus_def.col, 0);
    chk("rst_row", bus_def.row, 0);
    chk("rst_rgb", bus_def.rgb_out, 0);
    chk("rst_hsync", bus_def.hsync, 1);
    chk("rst_vsync", bus_def.vsync, 1);
    chk("rst_fs", bus_def.frame_start, 0);
    chk("rst_tick", bus_def.pixel_tick, 0);
    chk("rst_video_on", bus_def.video_on, 1);
    chk("rst_tick_div1", bus_sm.pixel_tick, 1);
    reset = 1'b0;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk);
      dcol[n] = bus_def.col;
      drow[n] = bus_def.row;
      dhs[n]  = bus_def.hsync;
      drgb[n] = bus_def.rgb_out;
      dtk[n]  = bus_def.pixel_tick;
      if (n <= 98) begin
        scol[n] = bus_sm.col;
        srow[n] = bus_sm.row;
        shs[n]  = bus_sm.hsync;
        svs[n]  = bus_sm.vsync;
        sfs[n]  = bus_sm.frame_start;
        srgb[n] = bus_sm.rgb_out;
        svid[n] = bus_sm.video_on;
      end
      if (n <= 20) begin
        qrgb[n] = bus_d4.rgb_out;
        qtk[n]  = bus_d4.pixel_tick;
      end
      bus_d4.rgb_in = (n % 4 == 3) ? (((n / 4) % 2 == 1) ? 3'b110 : 3'b011) : 3'b111;
    end
    hs_lo_def = 0;
    for (int n = 1; n <= 1700; n++) hs_lo_def += dhs[n] ? 0 : 1;
    hs_lo_sm = 0;
    vs_lo_sm = 0;
    fs_sm = 0;
    tk_sm = 0;
    for (int n = 1; n <= 98; n++) begin
      hs_lo_sm += shs[n] ? 0 : 1;
      vs_lo_sm += svs[n] ? 0 : 1;
      fs_sm    += sfs[n] ? 1 : 0;
    end
    chk("def_first_tick", dtk[1], 1);
    chk("def_col_after_div", dcol[2], 1);
    chk("def_row_after_div", drow[2], 0);
    chk("def_col_799", dcol[1599], 799);
    chk("def_col_wrap", dcol[1600], 0);
    chk("def_row_inc", drow[1600], 1);
    chk("def_hs_before", dhs[1313], 1);
    chk("def_hs_fall656", dhs[1314], 0);
    chk("def_hs_last_low", dhs[1505], 0);
    chk("def_hs_rise", dhs[1506], 1);
    chk("def_hs_width", hs_lo_def, 192);
    chk("def_rgb_latency0", drgb[1], 0);
    chk("def_rgb_first", drgb[2], 3'b101);
    chk("def_rgb_col639", drgb[1281], 3'b101);
    chk("def_rgb_col640", drgb[1282], 0);
    chk("def_rgb_col799", drgb[1600], 0);
    chk("sm_col13", scol[13], 13);
    chk("sm_col_wrap", scol[14], 0);
    chk("sm_row_inc", srow[14], 1);
    chk("sm_last_col", scol[97], 13);
    chk("sm_last_row", srow[97], 6);
    chk("sm_fs_pulse", sfs[97], 1);
    chk("sm_wrap_col", scol[98], 0);
    chk("sm_wrap_row", srow[98], 0);
    chk("sm_fs_count", fs_sm, 1);
    chk("sm_hs_before", shs[10], 1);
    chk("sm_hs_fall", shs[11], 0);
    chk("sm_hs_low2", shs[12], 0);
    chk("sm_hs_rise", shs[13], 1);
    chk("sm_hs_total", hs_lo_sm, 14);
    chk("sm_vs_before", svs[70], 1);
    chk("sm_vs_fall", svs[71], 0);
    chk("sm_vs_last", svs[84], 0);
    chk("sm_vs_rise", svs[85], 1);
    chk("sm_vs_total", vs_lo_sm, 14);
    chk("sm_rgb_col7", srgb[8], 3'b101);
    chk("sm_rgb_col8", srgb[9], 0);
    chk("sm_rgb_row3", srgb[50], 3'b101);
    chk("sm_rgb_row4", srgb[57], 0);
    chk("sm_vid_on", svid[3], 1);
    chk("sm_vid_col8", svid[8], 0);
    chk("sm_vid_row4", svid[56], 0);
    chk("d4_tick", qtk[3], 1);
    chk("d4_no_tick", qtk[4], 0);
    chk("d4_rgb_p0", qrgb[4], 3'b011);
    chk("d4_rgb_hold", qrgb[7], 3'b011);
    chk("d4_rgb_p1", qrgb[8], 3'b110);
    chk("d4_rgb_p2", qrgb[12], 3'b011);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_col", bus_def.col, 0);
    chk("mid_rst_row", bus_def.row, 0);
    chk("mid_rst_rgb", bus_def.rgb_out, 0);
    chk("mid_rst_hsync", bus_def.hsync, 1);
    chk("mid_rst_sm_col", bus_sm.col, 0);
    chk("mid_rst_sm_row", bus_sm.row, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_fs", bus_def.frame_start, 0);
    chk("rel_col_tick1", bus_def.col, 0);
    @(negedge clk);
    chk("rel_col", bus_def.col, 1);
    chk("rel_row", bus_def.row, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
